// File: rtl/acf_axis_packer_if.sv
// acf_axis_packer_if
// Purpose : 32-bit AXI4-Stream style bus (data, valid, ready, last) carrying
//           the packed ACF word stream out of acf_axis_packer.
// Signals : tdata  - stream data word
//           tvalid - word valid
//           tready - downstream ready
//           tlast  - last word of a frame
// Modports: master (drives tdata/tvalid/tlast, samples tready)
//           slave  (samples tdata/tvalid/tlast, drives tready)
interface acf_axis_packer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/acf_axis_packer.sv
// acf_axis_packer
// Purpose : Buffers ACF elements from the correlator in an element FIFO and
//           serializes each one as two 32-bit stream words (low word, then
//           zero-extended high word), marking the end of every frame with tlast.
//           Elements arriving while the FIFO is full are dropped and counted;
//           frame alignment is kept regardless of drops.
// Macro   : ACF_FRAME_HEADER_EN - when defined, a header word
//           {16'hACF0, frame_seq} is emitted before element 0 of each frame.
// Ports   : CLK        - clock, rising edge
//           rst        - synchronous active-high reset
//           acfEl      - ACF element (NUM_BINS+33 bits)
//           wrEn       - acfEl valid, no backpressure
//           clr_ovf    - clears overflow and drop_cnt
//           m_axis     - output stream (acf_axis_packer_if.master)
//           overflow   - sticky drop flag
//           drop_cnt   - saturating count of dropped elements
//           fifo_level - FIFO occupancy in elements
module acf_axis_packer #(
    parameter int NUM_BINS   = 20,
    parameter int BIN_SIZE   = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic [NUM_BINS+32:0]          acfEl,
    input  logic                          wrEn,
    input  logic                          clr_ovf,
    acf_axis_packer_if.master             m_axis,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int EW          = NUM_BINS + 33;
    localparam int FRAME_ELEMS = 1 + BIN_SIZE * (NUM_BINS + 1);
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int LW          = AW + 1;
    localparam int IW          = $clog2(FRAME_ELEMS + 1);
`ifdef ACF_FRAME_HEADER_EN
    localparam int DW          = EW + 2;   // {first_tag, last_tag, element}
`else
    localparam int DW          = EW + 1;   // {last_tag, element}
`endif

    // state | meaning
    // IDLE  | no word presented, waiting for FIFO data
    // HDR   | presenting frame header word (header build only)
    // LO    | presenting low word of FIFO head
    // HI    | presenting high word of FIFO head, pop on handshake
`ifdef ACF_FRAME_HEADER_EN
    typedef enum logic [1:0] {IDLE, HDR, LO, HI} state_t;
`else
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
`endif

    state_t            state, state_nxt;
    logic [DW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [IW-1:0]     in_idx;
    logic              level_seen;
    logic              full, push, pop, drop, last_tag;
    logic [DW-1:0]     head, wr_word;
    logic              tvalid, tlast;
    logic [31:0]       tdata;
`ifdef ACF_FRAME_HEADER_EN
    logic [DW-1:0]     next_head;
    logic [15:0]       frame_seq;
    logic              hdr_hs;
`endif

    assign full     = (fifo_level == LW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = wrEn & ~rst & (~full | pop);
    assign drop     = wrEn & ~rst & ~push;
    assign last_tag = (in_idx == IW'(FRAME_ELEMS - 1));
    assign head     = mem[rd_ptr];
`ifdef ACF_FRAME_HEADER_EN
    assign next_head = mem[rd_ptr + AW'(1)];
    assign wr_word   = {(in_idx == '0), last_tag, acfEl};
`else
    assign wr_word   = {last_tag, acfEl};
`endif

    assign m_axis.tvalid = tvalid;
    assign m_axis.tdata  = tdata;
    assign m_axis.tlast  = tlast;

    always_ff @(posedge CLK) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tvalid    = 1'b0;
        tdata     = '0;
        tlast     = 1'b0;
        pop       = 1'b0;
`ifdef ACF_FRAME_HEADER_EN
        hdr_hs    = 1'b0;
`endif
        if (!rst) begin
            case (state)
                IDLE: begin
                    // level_seen delays the start by one cycle so the first word
                    // appears two edges after the write into an empty FIFO.
                    if (level_seen && fifo_level != '0) begin
`ifdef ACF_FRAME_HEADER_EN
                        state_nxt = head[EW+1] ? HDR : LO;
`else
                        state_nxt = LO;
`endif
                    end
                end
`ifdef ACF_FRAME_HEADER_EN
                HDR: begin
                    tvalid = 1'b1;
                    tdata  = {16'hACF0, frame_seq};
                    if (m_axis.tready) begin
                        hdr_hs    = 1'b1;
                        state_nxt = LO;
                    end
                end
`endif
                LO: begin
                    tvalid = 1'b1;
                    tdata  = head[31:0];
                    if (m_axis.tready) state_nxt = HI;
                end
                HI: begin
                    tvalid = 1'b1;
                    tdata  = 32'(head[EW-1:32]);
                    tlast  = head[EW];
                    if (m_axis.tready) begin
                        pop = 1'b1;
                        // More than the element being popped means the stream continues.
                        if (fifo_level > LW'(1)) begin
`ifdef ACF_FRAME_HEADER_EN
                            state_nxt = next_head[EW+1] ? HDR : LO;
`else
                            state_nxt = LO;
`endif
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            level_seen <= 1'b0;
            in_idx     <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
`ifdef ACF_FRAME_HEADER_EN
            frame_seq  <= '0;
`endif
        end else begin
            level_seen <= (fifo_level != '0);
            if (wrEn) in_idx <= last_tag ? '0 : in_idx + IW'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_level <= fifo_level + LW'(1);
            else if (pop && !push) fifo_level <= fifo_level - LW'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (clr_ovf)                    drop_cnt <= 16'd1;
                else if (drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
`ifdef ACF_FRAME_HEADER_EN
            if (hdr_hs) frame_seq <= frame_seq + 16'd1;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wr_word;
    end
endmodule

// File: tb/tb_acf_axis_packer.sv
module tb_acf_axis_packer;
    localparam int EW    = 53;
    localparam int FE    = 169;
`ifdef ACF_FRAME_HEADER_EN
    localparam int NF    = 2;
`else
    localparam int NF    = 1;
`endif

    logic          CLK = 1'b0;
    logic          rst;
    logic [EW-1:0] acfEl;
    logic          wrEn;
    logic          clr_ovf;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic [6:0]    fifo_level;

    acf_axis_packer_if axis ();

    acf_axis_packer dut (
        .CLK        (CLK),
        .rst        (rst),
        .acfEl      (acfEl),
        .wrEn       (wrEn),
        .clr_ovf    (clr_ovf),
        .m_axis     (axis),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    int          got_cyc[$];
    int          m_idx;
    logic [15:0] m_seq;
    int          n_vec = 0;
    int          n_err = 0;

    always @(negedge CLK) begin
        if (!rst && axis.tvalid && axis.tready) begin
            got_q.push_back({axis.tlast, axis.tdata});
            got_cyc.push_back(cyc);
        end
    end

    function automatic logic [EW-1:0] rand_el();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[EW-1:0];
    endfunction

    // Reference: each stored element becomes [header if frame index 0], low, high words.
    task automatic model_add(input logic [EW-1:0] v, input bit stored);
        logic [31:0] hi;
        hi = 32'(v[EW-1:32]);
        if (stored) begin
`ifdef ACF_FRAME_HEADER_EN
            if (m_idx == 0) begin
                exp_q.push_back({1'b0, 16'hACF0, m_seq});
                m_seq++;
            end
`endif
            exp_q.push_back({1'b0, v[31:0]});
            exp_q.push_back({(m_idx == FE - 1), hi});
        end
        m_idx = (m_idx == FE - 1) ? 0 : m_idx + 1;
    endtask

    task automatic put(input logic [EW-1:0] v, input bit stored);
        wrEn  = 1'b1;
        acfEl = v;
        model_add(v, stored);
        @(posedge CLK); #1;
        wrEn  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; wrEn = 1'b0; clr_ovf = 1'b0; axis.tready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;
        m_idx = 0; m_seq = '0;
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic drain(output bit timed_out);
        timed_out = 1'b1;
        axis.tready = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (got_q.size() >= exp_q.size() && !axis.tvalid) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec += 6;
        if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL reset tvalid: got %b expected 0", axis.tvalid); end
        if (axis.tlast !== 1'b0)  begin n_err++; $display("FAIL reset tlast: got %b expected 0", axis.tlast); end
        if (axis.tdata !== 32'h0) begin n_err++; $display("FAIL reset tdata: got %h expected 0", axis.tdata); end
        if (fifo_level !== 7'd0)  begin n_err++; $display("FAIL reset fifo_level: got %0d expected 0", fifo_level); end
        if (overflow !== 1'b0)    begin n_err++; $display("FAIL reset overflow: got %b expected 0", overflow); end
        if (drop_cnt !== 16'd0)   begin n_err++; $display("FAIL reset drop_cnt: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_latency();
        logic [32:0] w;
        bit to;
        apply_reset();
        axis.tready = 1'b1;
        put(rand_el(), 1'b1);
        w = exp_q[0];
        n_vec++;
        if (fifo_level !== 7'd1) begin n_err++; $display("FAIL latency level after write: got %0d expected 1", fifo_level); end
        @(posedge CLK); #1;
        n_vec++;
        if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL latency tvalid at n+1: got %b expected 0", axis.tvalid); end
        @(posedge CLK); #1;
        n_vec += 2;
        if (axis.tvalid !== 1'b1) begin n_err++; $display("FAIL latency tvalid at n+2: got %b expected 1", axis.tvalid); end
        if (axis.tdata !== w[31:0]) begin n_err++; $display("FAIL latency first word: got %h expected %h", axis.tdata, w[31:0]); end
        drain(to);
        n_vec += 2;
        if (to) begin n_err++; $display("FAIL latency drain: got timeout expected idle"); end
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL latency word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL latency word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_frame();
        bit to;
        int nlast;
        apply_reset();
        axis.tready = 1'b1;
        for (int k = 0; k < NF * FE; k++) begin
            put(EW'(k), 1'b1);
            if (k % 4 == 3) repeat (3) begin @(posedge CLK); #1; end
        end
        drain(to);
        n_vec += 2;
        if (to) begin n_err++; $display("FAIL frame drain: got timeout expected idle"); end
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL frame word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        nlast = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL frame word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
            if (got_q[i][32]) nlast++;
        end
        n_vec += 2;
        if (nlast != NF) begin n_err++; $display("FAIL frame tlast count: got %0d expected %0d", nlast, NF); end
        if (got_q.size() > 0 && got_cyc[got_cyc.size()-1] - got_cyc[0] != got_q.size() - 1) begin
            n_err++;
            $display("FAIL frame bubbles: got span %0d expected %0d", got_cyc[got_cyc.size()-1] - got_cyc[0], got_q.size() - 1);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        apply_reset();
        put(53'h1_2345_6789, 1'b1);
        for (int i = 0; i < 10 && !axis.tvalid; i++) begin @(posedge CLK); #1; end
        n_vec++;
        if (axis.tvalid !== 1'b1) begin n_err++; $display("FAIL bp tvalid rise: got %b expected 1", axis.tvalid); end
`ifdef ACF_FRAME_HEADER_EN
        axis.tready = 1'b1;
        @(posedge CLK); #1;
        axis.tready = 1'b0;
`endif
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (axis.tvalid !== 1'b1 || axis.tdata !== 32'h23456789 || axis.tlast !== 1'b0) begin
                n_err++;
                $display("FAIL bp hold cycle %0d: got v=%b d=%h l=%b expected v=1 d=23456789 l=0", i, axis.tvalid, axis.tdata, axis.tlast);
            end
            @(posedge CLK); #1;
        end
        drain(to);
        n_vec += 2;
        if (to) begin n_err++; $display("FAIL bp drain: got timeout expected idle"); end
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        bit to;
        apply_reset();
        for (int k = 0; k < 70; k++) put(EW'(k), k < 64);
        n_vec += 3;
        if (overflow !== 1'b1)    begin n_err++; $display("FAIL ovf flag: got %b expected 1", overflow); end
        if (drop_cnt !== 16'd6)   begin n_err++; $display("FAIL ovf drop_cnt: got %0d expected 6", drop_cnt); end
        if (fifo_level !== 7'd64) begin n_err++; $display("FAIL ovf fifo_level: got %0d expected 64", fifo_level); end
        drain(to);
        n_vec += 2;
        if (to) begin n_err++; $display("FAIL ovf drain: got timeout expected idle"); end
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_clr_ovf();
        bit to;
        apply_reset();
        for (int k = 0; k < 69; k++) put(EW'(k), k < 64);
        n_vec += 2;
        if (drop_cnt !== 16'd5) begin n_err++; $display("FAIL clr pre drop_cnt: got %0d expected 5", drop_cnt); end
        if (overflow !== 1'b1)  begin n_err++; $display("FAIL clr pre overflow: got %b expected 1", overflow); end
        clr_ovf = 1'b1;
        put(EW'(69), 1'b0);
        clr_ovf = 1'b0;
        n_vec += 2;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL clr+drop overflow: got %b expected 1", overflow); end
        if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL clr+drop drop_cnt: got %0d expected 1", drop_cnt); end
        clr_ovf = 1'b1;
        @(posedge CLK); #1;
        clr_ovf = 1'b0;
        n_vec += 2;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL clr overflow: got %b expected 0", overflow); end
        if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL clr drop_cnt: got %0d expected 0", drop_cnt); end
        drain(to);
        n_vec += 2;
        if (to) begin n_err++; $display("FAIL clr drain: got timeout expected idle"); end
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL clr word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL clr word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        logic [32:0] w;
        apply_reset();
        axis.tready = 1'b1;
        for (int k = 0; k < 50; k++) put(rand_el(), 1'b1);
        rst = 1'b1;
        wrEn = 1'b1;
        acfEl = rand_el();
        #1;
        n_vec += 2;
        if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL midrst tvalid in reset: got %b expected 0", axis.tvalid); end
        if (axis.tdata !== 32'h0) begin n_err++; $display("FAIL midrst tdata in reset: got %h expected 0", axis.tdata); end
        @(posedge CLK); #1;
        rst = 1'b0; wrEn = 1'b0;
        m_idx = 0; m_seq = '0;
        exp_q.delete(); got_q.delete(); got_cyc.delete();
        n_vec++;
        if (fifo_level !== 7'd0) begin n_err++; $display("FAIL midrst fifo_level: got %0d expected 0", fifo_level); end
        for (int k = 0; k < FE; k++) begin
            put(EW'(k), 1'b1);
            if (k % 4 == 3) repeat (3) begin @(posedge CLK); #1; end
        end
        drain(to);
        n_vec += 2;
        if (to) begin n_err++; $display("FAIL midrst drain: got timeout expected idle"); end
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL midrst word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL midrst word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > 0) begin
            w = got_q[got_q.size()-1];
            n_vec++;
            if (w !== {1'b1, 32'h0}) begin n_err++; $display("FAIL midrst final word: got %h expected 100000000", w); end
        end
    endtask

    task automatic test_random();
        bit to;
        logic pv, pr, pl;
        logic [31:0] pd;
        int left;
        apply_reset();
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        for (int r = 0; r < 8; r++) begin
            left = $urandom_range(10, 40);
            while (left > 0) begin
                if (pv && !pr) begin
                    n_vec++;
                    if (axis.tvalid !== 1'b1 || axis.tdata !== pd || axis.tlast !== pl) begin
                        n_err++;
                        $display("FAIL rand stall hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b", axis.tvalid, axis.tdata, axis.tlast, pd, pl);
                    end
                end
                axis.tready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) != 0) begin
                    wrEn = 1'b1;
                    acfEl = rand_el();
                    model_add(acfEl, 1'b1);
                    left--;
                end else begin
                    wrEn = 1'b0;
                end
                pv = axis.tvalid; pr = axis.tready; pd = axis.tdata; pl = axis.tlast;
                @(posedge CLK); #1;
            end
            wrEn = 1'b0;
            pv = 1'b0;
            drain(to);
            n_vec += 2;
            if (to) begin n_err++; $display("FAIL rand round %0d drain: got timeout expected idle", r); end
            if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand round %0d word count: got %0d expected %0d", r, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand round %0d word %0d: got %h expected %h", r, i, got_q[i], exp_q[i]); end
            end
            exp_q.delete(); got_q.delete(); got_cyc.delete();
        end
        n_vec++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL rand overflow: got %b expected 0", overflow); end
    endtask

    initial begin
        rst = 1'b1; wrEn = 1'b0; clr_ovf = 1'b0; acfEl = '0; axis.tready = 1'b0;
        test_reset();
        test_latency();
        test_frame();
        test_backpressure();
        test_overflow();
        test_clr_ovf();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/acf_axis_packer.md
ACF_AXIS_PACKER -- requirements
Module: acf_axis_packer

Interface
REQ-001 SHALL have parameter NUM_BINS, default 20: ACF bin count of the upstream correlator; legal range 1..31.
REQ-002 SHALL have parameter BIN_SIZE, default 8: lags per bin; frame length FRAME_ELEMS = 1 + BIN_SIZE*(NUM_BINS+1), which is 169 at defaults.
REQ-003 SHALL have parameter FIFO_DEPTH, default 64: element FIFO depth; power of 2, at least 4.
REQ-004 SHALL have port CLK, input, 1: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port acfEl, input, NUM_BINS+33 (EW): ACF element from the correlator.
REQ-007 SHALL have port wrEn, input, 1: acfEl is valid this cycle; there is no backpressure toward the correlator.
REQ-008 SHALL have port clr_ovf, input, 1: clears the sticky overflow flag and drop_cnt.
REQ-009 SHALL have port m_axis_tdata, output, 32: output stream data.
REQ-010 SHALL have port m_axis_tvalid, output, 1: output stream valid.
REQ-011 SHALL have port m_axis_tready, input, 1: downstream ready.
REQ-012 SHALL have port m_axis_tlast, output, 1: marks the last word of a frame.
REQ-013 SHALL have port overflow, output, 1: sticky flag; set when an element is dropped.
REQ-014 SHALL have port drop_cnt, output, 16: count of dropped elements, saturating at 0xFFFF.
REQ-015 SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1: current FIFO occupancy in elements.

Function
REQ-016 SHALL write {last_tag, acfEl} into the FIFO on the edge where wrEn=1 and the FIFO is not full; last_tag = (in_idx == FRAME_ELEMS-1).
REQ-017 SHALL advance in_idx on every wrEn, whether the element is stored or dropped, and wrap it from FRAME_ELEMS-1 to 0, so frame alignment survives drops.
REQ-018 SHALL, on wrEn with the FIFO full, drop the element, set overflow, and increment drop_cnt (saturating); FIFO contents are unchanged.
REQ-019 SHALL give a FIFO write precedence over a same-cycle FIFO read when the FIFO is full only if that read frees the slot; with a simultaneous read and write, fifo_level is unchanged.
REQ-020 SHALL emit each element as two words: the low word acfEl[31:0] first, then the high word, which is acfEl[EW-1:32] zero-extended to 32 bits.
REQ-021 SHALL run the serializer FSM through states IDLE, HDR, LO and HI. The transitions are:
- IDLE to LO (or to HDR, see REQ-030) when the FIFO is non-empty.
- LO to HI on handshake.
- HI to LO on handshake if the FIFO is non-empty, otherwise HI to IDLE.
- The element is popped on the HI handshake.
REQ-022 SHALL define a handshake as m_axis_tvalid & m_axis_tready; while tvalid=1 and tready=0, tdata and tlast SHALL be held stable.
REQ-023 SHALL deassert tvalid in IDLE only; with tready held at 1 and the FIFO non-empty, the stream SHALL carry one word per cycle with no bubbles.
REQ-024 SHALL assert tlast only on the HI word of an element whose last_tag is 1.
REQ-025 SHALL have a latency where wrEn sampled at edge n into an empty FIFO, in IDLE, gives tvalid=1 with that element's LO word after edge n+2.
REQ-026 SHALL let clr_ovf clear overflow and drop_cnt; if a drop occurs in the same cycle, the drop wins (overflow=1, drop_cnt=1).
REQ-027 SHALL drive fifo_level as the registered occupancy, updated on the same edge as the write or pop.

Reset
REQ-028 SHALL, while rst=1, clear the FIFO pointers, in_idx, frame_seq, overflow and drop_cnt, put the FSM in IDLE, and drive m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0 and fifo_level=0.
REQ-029 SHALL, on reset mid-frame, discard partial frame state; the first wrEn after reset is element 0 of a new frame, and wrEn during rst=1 is ignored.

Configuration
REQ-030 SHALL, when macro ACF_FRAME_HEADER_EN is defined:
- Enter HDR before the LO word of every element with in-frame index 0.
- Emit the header word {16'hACF0, frame_seq[15:0]}.
- Increment frame_seq (wrapping at 16 bits) on the header handshake.
- Make a frame 2*FRAME_ELEMS+1 words long.
- Shift the REQ-025 latency so that the header appears after edge n+2.
To carry the in-frame index, the FIFO SHALL store a first_tag bit alongside last_tag. When the macro is undefined, HDR, frame_seq and first_tag SHALL be absent and a frame SHALL be 2*FRAME_ELEMS words.

Verification
REQ-031 SHALL cover the single-frame case at defaults with no header and tready=1: 169 wrEn pulses with element k=k -> 338 words, 0,0,1,0,...,168,0, with tlast only on word 338.
REQ-032 SHALL cover backpressure: tready=0 for 10 cycles while tvalid=1 on the LO word of 0x1_2345_6789 -> tdata held at 0x23456789, then the HI word 0x00000001 follows with no word lost.
REQ-033 SHALL cover overflow: FIFO_DEPTH=64, tready=0, 70 back-to-back wrEn -> overflow=1, drop_cnt=6, fifo_level=64; after tready=1, exactly elements 0..63 are delivered.
REQ-034 SHALL cover clr_ovf: clr_ovf pulse in the same cycle as a drop with drop_cnt=5 -> overflow=1 and drop_cnt=1 on the next cycle.
REQ-035 SHALL cover reset mid-frame: rst for 1 cycle after 50 elements, then 169 elements -> tvalid=0 during reset, and tlast lands on the HI word of element 168 of the new frame.
REQ-036 SHALL cover the header with ACF_FRAME_HEADER_EN defined: two consecutive frames -> first words 0xACF00000 and 0xACF00001, each frame 339 words.
